pipeline_stall_controller: RTL and testbench

//  Consumer end of the load-use bubble request: turns hazard bubble, branch-flush, halt and debug run/step commands

---
 rtl/pipeline_stall_controller_pkg.sv | 14 +
 rtl/pipeline_stall_controller_if.sv | 35 +++
 rtl/pipeline_stall_controller_saturating_counter.sv | 23 ++
 rtl/pipeline_stall_controller.sv | 84 ++++++++
 tb/tb_pipeline_stall_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall controller: run-mode FSM encodings
// and the default statistics counter width.
package pipeline_stall_controller_pkg;

  localparam int CANT_BITS_CONTADOR_DEFAULT = 32;

  typedef logic [1:0] run_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard/debug command inputs and pipeline strobe/statistics outputs of the
// stall controller; the controller takes the slave side.
interface pipeline_stall_controller_if #(
  parameter int CANT_BITS_CONTADOR = 32
);
  logic                          i_bit_burbuja;
  logic                          i_branch_taken;
  logic                          i_halt_wb;
  logic                          i_start_continuous;
  logic                          i_start_step;
  logic                          i_step;
  logic                          i_clear;
  logic                          o_enable_pc;
  logic                          o_enable_if_id;
  logic                          o_enable_back;
  logic                          o_bubble_id_ex;
  logic                          o_flush_if_id;
  logic                          o_halted;
  logic [CANT_BITS_CONTADOR-1:0] o_cycle_count;
  logic [CANT_BITS_CONTADOR-1:0] o_stall_count;

  modport master (
    output i_bit_burbuja, i_branch_taken, i_halt_wb, i_start_continuous,
           i_start_step, i_step, i_clear,
    input  o_enable_pc, o_enable_if_id, o_enable_back, o_bubble_id_ex,
           o_flush_if_id, o_halted, o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_bit_burbuja, i_branch_taken, i_halt_wb, i_start_continuous,
           i_start_step, i_step, i_clear,
    output o_enable_pc, o_enable_if_id, o_enable_back, o_bubble_id_ex,
           o_flush_if_id, o_halted, o_cycle_count, o_stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller_saturating_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear
// takes priority over increment.
module saturating_counter #(
  parameter int CANT_BITS_CONTADOR = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_clear,
  input  logic                          i_inc,
  output logic [CANT_BITS_CONTADOR-1:0] o_count
);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_count <= '0;
    end else if (i_clear) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {CANT_BITS_CONTADOR{1'b1}})) begin
      o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Run-mode FSM that turns hazard bubbles, branch flushes, halt and debug
// run/step commands into per-stage enable/flush/bubble strobes plus statistics.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CANT_BITS_CONTADOR = CANT_BITS_CONTADOR_DEFAULT
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  pipeline_stall_controller_if.slave  bus
);

  run_state_t state;
  run_state_t state_nxt;
  logic       step_prev;
  logic       step_pulse;
  logic       adv;
  logic       start_run;

  assign step_pulse = bus.i_step & ~step_prev;
  assign start_run  = (state == ST_IDLE) & (bus.i_start_continuous | bus.i_start_step);

  always_comb begin
    adv = 1'b0;
    case (state)
      ST_RUN:  adv = 1'b1;
      ST_STEP: adv = step_pulse;
      default: adv = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.i_start_continuous)  state_nxt = ST_RUN;
        else if (bus.i_start_step)   state_nxt = ST_STEP;
      end
      // The halting instruction's own cycle still advances so it retires.
      ST_RUN, ST_STEP: begin
        if (adv && bus.i_halt_wb)    state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        if (bus.i_clear)             state_nxt = ST_IDLE;
      end
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      step_prev <= 1'b0;
    end else begin
      state     <= state_nxt;
      step_prev <= bus.i_step;
    end
  end

  // Bubble wins over flush: a stalled branch has not resolved on valid operands.
  assign bus.o_enable_pc    = adv & ~bus.i_bit_burbuja;
  assign bus.o_enable_if_id = adv & ~bus.i_bit_burbuja;
  assign bus.o_enable_back  = adv;
  assign bus.o_bubble_id_ex = adv & bus.i_bit_burbuja;
  assign bus.o_flush_if_id  = adv & bus.i_branch_taken & ~bus.i_bit_burbuja;
  assign bus.o_halted       = (state == ST_HALTED);

  saturating_counter #(.CANT_BITS_CONTADOR(CANT_BITS_CONTADOR)) u_cycle_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (start_run),
    .i_inc   (adv),
    .o_count (bus.o_cycle_count)
  );

  saturating_counter #(.CANT_BITS_CONTADOR(CANT_BITS_CONTADOR)) u_stall_counter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (start_run),
    .i_inc   (adv & bus.i_bit_burbuja),
    .o_count (bus.o_stall_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller with 4-bit counters so
// saturation is reachable in a few cycles.
module tb_pipeline_stall_controller;

  localparam int W = 4;
  localparam logic [1:0] M_IDLE = 2'd0, M_RUN = 2'd1, M_STEP = 2'd2, M_HALTED = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CANT_BITS_CONTADOR(W)) bus ();

  pipeline_stall_controller #(.CANT_BITS_CONTADOR(W)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic         pc;
    logic         ifid;
    logic         back;
    logic         bub;
    logic         flush;
    logic         halted;
    logic [W-1:0] cyc;
    logic [W-1:0] stl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [1:0]   m_state = M_IDLE;
  logic         m_prev  = 1'b0;
  logic [W-1:0] m_cyc   = '0;
  logic [W-1:0] m_stl   = '0;

  // One clock of stimulus: drive after the rising edge, predict, compare at the falling edge.
  task automatic drive_cycle(input logic rst, input logic bub, input logic br, input logic hlt,
                             input logic sc, input logic ss, input logic st, input logic clr);
    exp_t e;
    exp_t g;
    logic adv;
    @(posedge clk);
    #1;
    rst_n                  = rst;
    bus.i_bit_burbuja      = bub;
    bus.i_branch_taken     = br;
    bus.i_halt_wb          = hlt;
    bus.i_start_continuous = sc;
    bus.i_start_step       = ss;
    bus.i_step             = st;
    bus.i_clear            = clr;
    if (!rst) begin
      m_state = M_IDLE; m_prev = 1'b0; m_cyc = '0; m_stl = '0;
    end
    adv = rst && ((m_state == M_RUN) || ((m_state == M_STEP) && st && !m_prev));
    e.pc     = adv && !bub;
    e.ifid   = adv && !bub;
    e.back   = adv;
    e.bub    = adv && bub;
    e.flush  = adv && br && !bub;
    e.halted = (m_state == M_HALTED);
    e.cyc    = m_cyc;
    e.stl    = m_stl;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    checks++; if (bus.o_enable_pc !== g.pc) begin errors++; $display("FAIL en_pc got %b exp %b t=%0t", bus.o_enable_pc, g.pc, $time); end
    checks++; if (bus.o_enable_if_id !== g.ifid) begin errors++; $display("FAIL en_if_id got %b exp %b t=%0t", bus.o_enable_if_id, g.ifid, $time); end
    checks++; if (bus.o_enable_back !== g.back) begin errors++; $display("FAIL en_back got %b exp %b t=%0t", bus.o_enable_back, g.back, $time); end
    checks++; if (bus.o_bubble_id_ex !== g.bub) begin errors++; $display("FAIL bubble got %b exp %b t=%0t", bus.o_bubble_id_ex, g.bub, $time); end
    checks++; if (bus.o_flush_if_id !== g.flush) begin errors++; $display("FAIL flush got %b exp %b t=%0t", bus.o_flush_if_id, g.flush, $time); end
    checks++; if (bus.o_halted !== g.halted) begin errors++; $display("FAIL halted got %b exp %b t=%0t", bus.o_halted, g.halted, $time); end
    checks++; if (bus.o_cycle_count !== g.cyc) begin errors++; $display("FAIL cycle_count got %0d exp %0d t=%0t", bus.o_cycle_count, g.cyc, $time); end
    checks++; if (bus.o_stall_count !== g.stl) begin errors++; $display("FAIL stall_count got %0d exp %0d t=%0t", bus.o_stall_count, g.stl, $time); end
    if (rst) begin
      case (m_state)
        M_IDLE: begin
          if (sc)      begin m_state = M_RUN;  m_cyc = '0; m_stl = '0; end
          else if (ss) begin m_state = M_STEP; m_cyc = '0; m_stl = '0; end
        end
        M_RUN, M_STEP: begin
          if (adv && m_cyc != {W{1'b1}}) m_cyc = m_cyc + 1'b1;
          if (adv && bub && m_stl != {W{1'b1}}) m_stl = m_stl + 1'b1;
          if (adv && hlt) m_state = M_HALTED;
        end
        default: if (clr) m_state = M_IDLE;
      endcase
      m_prev = st;
    end
  endtask

  task automatic do_reset();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_cycle_count !== 4'd0 || bus.o_halted !== 1'b0 || bus.o_enable_back !== 1'b0) begin
      errors++; $display("FAIL reset_state got cyc=%0d halted=%b back=%b exp 0/0/0", bus.o_cycle_count, bus.o_halted, bus.o_enable_back);
    end
    drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_start_both();
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 1, 0, 0);
    repeat (10) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_cycle_count !== 4'd10) begin errors++; $display("FAIL run_count_10 got %0d exp 10", bus.o_cycle_count); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 0);
    repeat (5) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_cycle_count !== 4'd5) begin errors++; $display("FAIL pre_reset_count got %0d exp 5", bus.o_cycle_count); end
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_cycle_count !== 4'd0 || bus.o_enable_back !== 1'b0 || bus.o_enable_pc !== 1'b0) begin
      errors++; $display("FAIL mid_run_reset got cyc=%0d back=%b pc=%b exp 0/0/0", bus.o_cycle_count, bus.o_enable_back, bus.o_enable_pc);
    end
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_enable_back !== 1'b0) begin errors++; $display("FAIL idle_after_reset got back=%b exp 0", bus.o_enable_back); end
  endtask

  task automatic test_bubble_flush();
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 0);
    drive_cycle(1, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (bus.o_flush_if_id !== 1'b1) begin errors++; $display("FAIL branch_flush got %b exp 1", bus.o_flush_if_id); end
    drive_cycle(1, 1, 1, 0, 0, 0, 0, 0);
    checks++; if ({bus.o_enable_pc, bus.o_enable_if_id, bus.o_bubble_id_ex, bus.o_flush_if_id, bus.o_enable_back} !== 5'b00101) begin
      errors++; $display("FAIL bubble_wins got pc,ifid,bub,flush,back=%b exp 00101",
        {bus.o_enable_pc, bus.o_enable_if_id, bus.o_bubble_id_ex, bus.o_flush_if_id, bus.o_enable_back});
    end
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_stall_count !== 4'd1) begin errors++; $display("FAIL stall_count_1 got %0d exp 1", bus.o_stall_count); end
  endtask

  task automatic test_step();
    int n_adv;
    n_adv = 0;
    do_reset();
    drive_cycle(1, 0, 0, 0, 0, 1, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
      if (bus.o_enable_back === 1'b1) n_adv++;
    end
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (n_adv != 1) begin errors++; $display("FAIL step_held_advances got %0d exp 1", n_adv); end
    checks++; if (bus.o_cycle_count !== 4'd1) begin errors++; $display("FAIL step_count got %0d exp 1", bus.o_cycle_count); end
    drive_cycle(1, 0, 0, 0, 0, 0, 1, 0);
    checks++; if (bus.o_enable_back !== 1'b1) begin errors++; $display("FAIL second_step got %b exp 1", bus.o_enable_back); end
    drive_cycle(1, 0, 0, 1, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_halted !== 1'b0) begin errors++; $display("FAIL step_halt_no_adv got %b exp 0", bus.o_halted); end
  endtask

  task automatic test_halt();
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 1, 0, 0, 0, 0);
    checks++; if (bus.o_enable_back !== 1'b1) begin errors++; $display("FAIL halt_cycle_adv got %b exp 1", bus.o_enable_back); end
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_halted !== 1'b1 || bus.o_enable_back !== 1'b0 || bus.o_enable_pc !== 1'b0) begin
      errors++; $display("FAIL halted_frozen got halted=%b back=%b pc=%b exp 1/0/0", bus.o_halted, bus.o_enable_back, bus.o_enable_pc);
    end
    checks++; if (bus.o_cycle_count !== 4'd3) begin errors++; $display("FAIL halt_count got %0d exp 3", bus.o_cycle_count); end
    drive_cycle(1, 0, 0, 0, 1, 1, 1, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_halted !== 1'b0 || bus.o_cycle_count !== 4'd3) begin
      errors++; $display("FAIL clear_to_idle got halted=%b cyc=%0d exp 0/3", bus.o_halted, bus.o_cycle_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive_cycle(1, 0, 0, 0, 1, 0, 0, 0);
    repeat (20) drive_cycle(1, 1, 0, 0, 0, 0, 0, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.o_cycle_count !== 4'hF) begin errors++; $display("FAIL cycle_saturate got %h exp f", bus.o_cycle_count); end
    checks++; if (bus.o_stall_count !== 4'hF) begin errors++; $display("FAIL stall_saturate got %h exp f", bus.o_stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 80; i++) begin
      drive_cycle(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    bus.i_bit_burbuja = 0; bus.i_branch_taken = 0; bus.i_halt_wb = 0;
    bus.i_start_continuous = 0; bus.i_start_step = 0; bus.i_step = 0; bus.i_clear = 0;
    test_reset();
    test_start_both();
    test_reset_mid_run();
    test_bubble_flush();
    test_step();
    test_halt();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
